abs_diff_arbiter: RTL and testbench

ABS_DIFF_ARBITER -- requirements
Module: abs_diff_arbiter

---
 rtl/abs_diff_arbiter_if.sv | 29 ++
 rtl/abs_diff_arbiter.sv | 114 +++++++++++
 tb/tb_abs_diff_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/abs_diff_arbiter_if.sv
// Client-side bundle for abs_diff_arbiter: two request/operand ports plus result, status and counters.
// master = requesting clients, slave = the arbiter.
interface abs_diff_arbiter_if;
  logic       req0;
  logic [7:0] data_A0;
  logic [7:0] data_B0;
  logic       req1;
  logic [7:0] data_A1;
  logic [7:0] data_B1;
  logic       grant0;
  logic       grant1;
  logic       valid;
  logic [7:0] result;
  logic       borrow;
  logic       owner;
  logic       busy;
  logic [7:0] ops0;
  logic [7:0] ops1;

  modport master (
    output req0, data_A0, data_B0, req1, data_A1, data_B1,
    input  grant0, grant1, valid, result, borrow, owner, busy, ops0, ops1
  );

  modport slave (
    input  req0, data_A0, data_B0, req1, data_A1, data_B1,
    output grant0, grant1, valid, result, borrow, owner, busy, ops0, ops1
  );
endinterface

// File: rtl/abs_diff_arbiter.sv
// Round-robin two-client |A-B| unit: capture, subtract, conditional negate, report (1 op per 4 cycles).
// Valid pulses one cycle after the second edge following capture; requests are held off (ignored) while busy.
module abs_diff_arbiter (
  input  logic               clock,
  input  logic               reset,
  abs_diff_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] reg_a_q, reg_a_d;
  logic [7:0] reg_b_q, reg_b_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] ops0_q, ops0_d;
  logic [7:0] ops1_q, ops1_d;

  logic       any_req;
  logic       winner;
  logic [8:0] diff;

  assign any_req = bus.req0 | bus.req1;
  // On a tie the client that did not win last time goes first.
  assign winner  = (bus.req0 & bus.req1) ? ~last_owner_q : bus.req1;
  assign diff    = {1'b0, reg_a_q} + {1'b0, ~reg_b_q} + 9'd1;

  always_comb begin
    state_d      = state_q;
    reg_a_d      = reg_a_q;
    reg_b_d      = reg_b_q;
    carry_d      = carry_q;
    borrow_d     = borrow_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    ops0_d       = ops0_q;
    ops1_d       = ops1_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          reg_a_d      = winner ? bus.data_A1 : bus.data_A0;
          reg_b_d      = winner ? bus.data_B1 : bus.data_B0;
          owner_d      = winner;
          last_owner_d = winner;
          state_d      = SUB;
        end
      end
      SUB: begin
        carry_d  = diff[8];
        reg_a_d  = diff[7:0];
        borrow_d = ~diff[8];
        state_d  = CONV;
      end
      CONV: begin
        if (borrow_q) begin
          reg_a_d = ~reg_a_q + 8'd1;
        end
        state_d = DONE;
      end
      DONE: begin
        if (owner_q) begin
          ops1_d = ops1_q + 8'd1;
        end else begin
          ops0_d = ops0_q + 8'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      reg_a_q      <= 8'd0;
      reg_b_q      <= 8'd0;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      ops0_q       <= 8'd0;
      ops1_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      reg_a_q      <= reg_a_d;
      reg_b_q      <= reg_b_d;
      carry_q      <= carry_d;
      borrow_q     <= borrow_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      ops0_q       <= ops0_d;
      ops1_q       <= ops1_d;
    end
  end

  assign bus.grant0 = (state_q == SUB) & ~owner_q;
  assign bus.grant1 = (state_q == SUB) &  owner_q;
  assign bus.valid  = (state_q == DONE);
  assign bus.busy   = (state_q != IDLE);
  assign bus.result = reg_a_q;
  assign bus.borrow = borrow_q;
  assign bus.owner  = owner_q;
  assign bus.ops0   = ops0_q;
  assign bus.ops1   = ops1_q;

endmodule

// File: tb/tb_abs_diff_arbiter.sv
// Directed bench for abs_diff_arbiter: single clients, ties, boundary operands, reset mid-op, counter wrap.
module tb_abs_diff_arbiter;
  logic clock;
  logic reset;
  abs_diff_arbiter_if bus ();

  abs_diff_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks;
  int errors;
  logic [7:0] ops0_m;
  logic [7:0] ops1_m;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit client, input logic [7:0] a, input logic [7:0] b);
    if (client) begin
      bus.req1 = 1'b1; bus.data_A1 = a; bus.data_B1 = b;
    end else begin
      bus.req0 = 1'b1; bus.data_A0 = a; bus.data_B0 = b;
    end
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("rst_grant0", bus.grant0, 0);
      chk("rst_grant1", bus.grant1, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_ops0", bus.ops0, 0);
      chk("rst_ops1", bus.ops1, 0);
    end
    reset  = 1'b0;
    ops0_m = 8'd0;
    ops1_m = 8'd0;
  endtask

  // Waits for a grant, then follows the operation to completion and checks it.
  task automatic run_op(input string tag, input bit exp_own, input logic [7:0] exp_res, input bit exp_brw);
    int  n;
    bit  got;
    bit  who;
    n   = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(posedge clock); #1;
      n++;
      if (bus.grant0 | bus.grant1) got = 1'b1;
    end
    if (!got) begin
      chk({tag, "_grant_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_both_grants"}, bus.grant0 & bus.grant1, 0);
    chk({tag, "_grant_client"}, bus.grant1, exp_own);
    chk({tag, "_busy_sub"}, bus.busy, 1);
    who = bus.grant1;
    // Drop the request and scramble operands: the captured op must be unaffected.
    if (who) begin
      bus.req1 = 1'b0; bus.data_A1 = 8'($urandom); bus.data_B1 = 8'($urandom);
    end else begin
      bus.req0 = 1'b0; bus.data_A0 = 8'($urandom); bus.data_B0 = 8'($urandom);
    end
    @(posedge clock); #1;
    chk({tag, "_valid_conv"}, bus.valid, 0);
    chk({tag, "_grants_conv"}, bus.grant0 | bus.grant1, 0);
    @(posedge clock); #1;
    chk({tag, "_valid"}, bus.valid, 1);
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_borrow"}, bus.borrow, exp_brw);
    chk({tag, "_owner"}, bus.owner, exp_own);
    if (exp_own) ops1_m = ops1_m + 8'd1;
    else         ops0_m = ops0_m + 8'd1;
    @(posedge clock); #1;
    chk({tag, "_valid_idle"}, bus.valid, 0);
    chk({tag, "_result_hold"}, bus.result, exp_res);
    chk({tag, "_ops0"}, bus.ops0, ops0_m);
    chk({tag, "_ops1"}, bus.ops1, ops1_m);
  endtask

  initial begin
    logic [7:0] a;
    int         n;
    bit         got;
    checks   = 0;
    errors   = 0;
    ops0_m   = 8'd0;
    ops1_m   = 8'd0;
    bus.req0 = 1'b0; bus.data_A0 = 8'd0; bus.data_B0 = 8'd0;
    bus.req1 = 1'b0; bus.data_A1 = 8'd0; bus.data_B1 = 8'd0;
    reset    = 1'b1;
    apply_reset();

    // Single clients
    set_req(0, 8'hAA, 8'h55);
    run_op("c0_aa_55", 0, 8'h55, 0);
    set_req(1, 8'h55, 8'hAA);
    run_op("c1_55_aa", 1, 8'h55, 1);

    // Ties after reset: 0,1 then 0,1 again
    apply_reset();
    set_req(0, 8'h10, 8'h03);
    set_req(1, 8'h03, 8'h10);
    run_op("tie1_a", 0, 8'h0D, 0);
    run_op("tie1_b", 1, 8'h0D, 1);
    set_req(0, 8'h80, 8'h7F);
    set_req(1, 8'h7F, 8'h80);
    run_op("tie2_a", 0, 8'h01, 0);
    run_op("tie2_b", 1, 8'h01, 1);

    // Boundary operands
    set_req(0, 8'h00, 8'hFF);
    run_op("b_00_ff", 0, 8'hFF, 1);
    set_req(1, 8'h0F, 8'h0F);
    run_op("b_0f_0f", 1, 8'h00, 0);
    set_req(0, 8'hFF, 8'h00);
    run_op("b_ff_00", 0, 8'hFF, 0);

    // Reset while the op is in CONV
    set_req(0, 8'h12, 8'h34);
    n   = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(posedge clock); #1;
      n++;
      if (bus.grant0) got = 1'b1;
    end
    chk("rconv_grant", got, 1);
    bus.req0 = 1'b0;
    @(posedge clock); #1;
    chk("rconv_busy", bus.busy, 1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("rconv_valid", bus.valid, 0);
      chk("rconv_busy_rst", bus.busy, 0);
      chk("rconv_ops0", bus.ops0, 0);
    end
    reset  = 1'b0;
    ops0_m = 8'd0;
    ops1_m = 8'd0;
    set_req(0, 8'h34, 8'h12);
    run_op("after_rst", 0, 8'h22, 0);

    // ops0 wrap over 256 ops, ops1 left alone
    apply_reset();
    set_req(1, 8'h05, 8'h07);
    run_op("wrap_pre1", 1, 8'h02, 1);
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      set_req(0, a, 8'h80);
      run_op("wrap", 0, (a >= 8'h80) ? a - 8'h80 : 8'h80 - a, (a < 8'h80));
    end
    chk("wrap_ops0", bus.ops0, 8'h00);
    chk("wrap_ops1", bus.ops1, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
